tdc_spi_master_n: RTL and testbench

TDC_SPI_MASTER_N -- requirements
Module: tdc_spi_master_n

---
 rtl/tdc_spi_master_n.sv | 203 ++++++++++++++++++++
 tb/tb_tdc_spi_master_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_spi_master_n.sv
`default_nettype none
// ============================================================================
// Module   : tdc_spi_master_n
// Purpose  : SPI master for a TDC front end; configurable CPOL/CPHA, word
//            width, SCK divider, CS burst hold and abort with CS recovery gap.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_spi_master_n #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8,
    parameter int CPOL    = 0,
    parameter int CPHA    = 0,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cs_keep,
    input  logic              abort,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              new_data
);

    localparam int c_DIV_W  = $clog2(CLK_DIV + 1);
    localparam int c_EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int c_GAP_W  = $clog2(CS_GAP + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_W - 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_ALL  = c_EDGE_W'(2 * DATA_W);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(CS_GAP - 1);
    localparam logic                c_SCK_IDLE  = (CPOL != 0);
    localparam logic                c_CPHA1     = (CPHA != 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        TRANSFER = 3'd2,
        HOLD     = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_DIV_W-1:0]  r_div,   w_div_nxt;
    logic [c_EDGE_W-1:0] r_edge,  w_edge_nxt;
    logic [c_GAP_W-1:0]  r_gap,   w_gap_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [DATA_W-1:0]   r_dout,  w_dout_nxt;
    logic                r_keep,  w_keep_nxt;
    logic                r_cs,    w_cs_nxt;
    logic                r_sck,   w_sck_nxt;
    logic                r_mosi,  w_mosi_nxt;
    logic                r_nd,    w_nd_nxt;
    logic                w_do_edge;

    // r_edge counts SCK edges already produced; the edge index parity gives
    // leading (even) versus trailing (odd).
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_edge_nxt  = r_edge;
        w_gap_nxt   = r_gap;
        w_shift_nxt = r_shift;
        w_keep_nxt  = r_keep;
        w_cs_nxt    = r_cs;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_dout_nxt  = r_dout;
        w_nd_nxt    = 1'b0;
        w_do_edge   = 1'b0;

        if (abort) begin
            w_state_nxt = GAP;
            w_cs_nxt    = 1'b1;
            w_sck_nxt   = c_SCK_IDLE;
            w_mosi_nxt  = 1'b0;
            w_div_nxt   = '0;
            w_edge_nxt  = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = SETUP;
                        w_shift_nxt = data_in;
                        w_keep_nxt  = cs_keep;
                        w_cs_nxt    = 1'b0;
                        w_sck_nxt   = c_SCK_IDLE;
                        w_mosi_nxt  = data_in[DATA_W-1];
                        w_div_nxt   = '0;
                        w_edge_nxt  = '0;
                    end
                end
                SETUP: begin
                    if (r_div == c_DIV_LAST) begin
                        w_state_nxt = TRANSFER;
                        w_div_nxt   = '0;
                        w_do_edge   = 1'b1;
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                TRANSFER: begin
                    if (r_div == c_DIV_LAST) begin
                        w_div_nxt = '0;
                        if (r_edge == c_EDGE_ALL) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_do_edge = 1'b1;
                        end
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                HOLD: begin
                    if (r_div == c_DIV_LAST) begin
                        w_dout_nxt = r_shift;
                        w_nd_nxt   = 1'b1;
                        w_mosi_nxt = 1'b0;
                        w_div_nxt  = '0;
                        w_edge_nxt = '0;
                        w_gap_nxt  = '0;
                        if (r_keep) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = GAP;
                            w_cs_nxt    = 1'b1;
                        end
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cs_nxt    = 1'b1;
                    w_sck_nxt   = c_SCK_IDLE;
                end
            endcase
        end

        // Receive and transmit share one register: sampling shifts miso in
        // at the LSB, which also exposes the next transmit bit at the MSB.
        if (w_do_edge) begin
            w_edge_nxt = r_edge + 1'b1;
            w_sck_nxt  = ~r_sck;
            if (r_edge[0] == c_CPHA1) begin
                w_shift_nxt = {r_shift[DATA_W-2:0], miso};
            end else if (r_edge != c_EDGE_LAST) begin
                w_mosi_nxt = r_shift[DATA_W-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_edge  <= '0;
            r_gap   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_keep  <= 1'b0;
            r_cs    <= 1'b1;
            r_sck   <= c_SCK_IDLE;
            r_mosi  <= 1'b0;
            r_nd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_edge  <= w_edge_nxt;
            r_gap   <= w_gap_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_keep  <= w_keep_nxt;
            r_cs    <= w_cs_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_nd    <= w_nd_nxt;
        end
    end

    assign mosi     = r_mosi;
    assign sck      = r_sck;
    assign cs       = r_cs;
    assign data_out = r_dout;
    assign busy     = (r_state != IDLE);
    assign new_data = r_nd;

endmodule
`default_nettype wire

// File: tb/tb_tdc_spi_master_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_spi_master_n
// Purpose  : Self-checking bench: two SPI masters (mode 0 / 8 bit and
//            mode 3 / 24 bit) against a behavioural TDC slave and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_spi_master_n;

    localparam int W0 = 8,  H0 = 2, G0 = 2, POL0 = 0, PHA0 = 0;
    localparam int W1 = 24, H1 = 3, G1 = 3, POL1 = 1, PHA1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0 = 1'b0, keep0 = 1'b0, abort0 = 1'b0, loop0 = 1'b0;
    logic          start1 = 1'b0, keep1 = 1'b0, abort1 = 1'b0;
    logic [W0-1:0] din0 = '0, dout0;
    logic [W1-1:0] din1 = '0, dout1;
    logic [1:0]    mosi_v, sck_v, cs_v, busy_v, nd_v;
    logic [1:0]    miso_v = 2'b00;
    logic          miso0;

    assign miso0 = loop0 ? mosi_v[0] : miso_v[0];

    tdc_spi_master_n #(.CLK_DIV(H0), .DATA_W(W0), .CPOL(POL0), .CPHA(PHA0), .CS_GAP(G0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(din0), .cs_keep(keep0),
        .abort(abort0), .miso(miso0), .mosi(mosi_v[0]), .sck(sck_v[0]), .cs(cs_v[0]),
        .data_out(dout0), .busy(busy_v[0]), .new_data(nd_v[0])
    );

    tdc_spi_master_n #(.CLK_DIV(H1), .DATA_W(W1), .CPOL(POL1), .CPHA(PHA1), .CS_GAP(G1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(din1), .cs_keep(keep1),
        .abort(abort1), .miso(miso_v[1]), .mosi(mosi_v[1]), .sck(sck_v[1]), .cs(cs_v[1]),
        .data_out(dout1), .busy(busy_v[1]), .new_data(nd_v[1])
    );

    int errors = 0;
    int checks = 0;

    function automatic int wd(input int d);  return (d == 0) ? W0 : W1; endfunction
    function automatic int hd(input int d);  return (d == 0) ? H0 : H1; endfunction
    function automatic int gd(input int d);  return (d == 0) ? G0 : G1; endfunction
    function automatic logic pol(input int d); return (d == 0) ? (POL0 != 0) : (POL1 != 0); endfunction
    function automatic logic pha(input int d); return (d == 0) ? (PHA0 != 0) : (PHA1 != 0); endfunction
    function automatic logic [31:0] dout(input int d);
        return (d == 0) ? 32'(dout0) : 32'(dout1);
    endfunction
    function automatic logic [31:0] mask(input int d);
        return (d == 0) ? 32'h0000_00FF : 32'h00FF_FFFF;
    endfunction

    // Behavioural TDC slave and bus monitor; counters only ever grow.
    int          cs_low[2], lead[2], trail[2], nd_cnt[2], cs_rise[2];
    int          b_lead[2], b_trail[2];
    logic [31:0] rx[2], resp[2];
    logic [1:0]  prev_sck, prev_cs;

    initial begin
        for (int d = 0; d < 2; d++) begin
            cs_low[d] = 0; lead[d] = 0; trail[d] = 0; nd_cnt[d] = 0; cs_rise[d] = 0;
            rx[d] = '0;
        end
    end

    always @(negedge clk) begin
        int  idx;
        logic is_lead;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (!cs_v[d]) cs_low[d]++;
                if (cs_v[d] && !prev_cs[d]) cs_rise[d]++;
                if (nd_v[d]) nd_cnt[d]++;
                if (!cs_v[d] && (sck_v[d] != prev_sck[d])) begin
                    is_lead = (prev_sck[d] == pol(d));
                    if (is_lead) lead[d]++; else trail[d]++;
                    if (is_lead == !pha(d)) rx[d] = {rx[d][30:0], mosi_v[d]};
                end
                if (!pha(d)) idx = trail[d] - b_trail[d];
                else         idx = (lead[d] - b_lead[d] == 0) ? 0 : lead[d] - b_lead[d] - 1;
                miso_v[d] = (idx < wd(d)) ? resp[d][wd(d) - 1 - idx] : 1'b0;
            end
            prev_sck[d] = sck_v[d];
            prev_cs[d]  = cs_v[d];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic s, input logic [31:0] data,
                         input logic keep, input logic ab);
        if (d == 0) begin
            start0 = s; din0 = data[W0-1:0]; keep0 = keep; abort0 = ab;
        end else begin
            start1 = s; din1 = data[W1-1:0]; keep1 = keep; abort1 = ab;
        end
    endtask

    task automatic wait_idle(input int d, input string tag);
        int n;
        n = 0;
        while (busy_v[d] && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy_v[d]), 32'd0);
    endtask

    task automatic arm_slave(input int d, input logic [31:0] rsp);
        resp[d]    = rsp;
        b_lead[d]  = lead[d];
        b_trail[d] = trail[d];
    endtask

    // One word: expected data_out is the slave response, expected mosi bits
    // the transmitted word; frame timing follows from H, DATA_W and CS_GAP.
    task automatic frame(input int d, input logic [31:0] data, input logic keep,
                         input logic [31:0] rsp, input string tag);
        int   n, s_low, s_nd, s_lead;
        logic fresh;
        wait_idle(d, tag);
        fresh  = cs_v[d];
        s_low  = cs_low[d];
        s_nd   = nd_cnt[d];
        s_lead = lead[d];
        arm_slave(d, rsp);
        drive(d, 1'b1, data, keep, 1'b0);
        tick();
        drive(d, 1'b0, data, keep, 1'b0);
        n = 0;
        while (!nd_v[d] && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_nd"},     32'(nd_v[d]), 32'd1);
        check({tag, "_dout"},   dout(d), rsp & mask(d));
        check({tag, "_mosi"},   rx[d] & mask(d), data & mask(d));
        check({tag, "_pulses"}, 32'(lead[d] - s_lead), 32'(wd(d)));
        if (fresh) check({tag, "_cslow"}, 32'(cs_low[d] - s_low), 32'((2 * wd(d) + 2) * hd(d)));
        if (!keep) begin
            n = 0;
            while (busy_v[d] && n < 1000) begin
                if (!cs_v[d]) check({tag, "_gapcs"}, 32'(cs_v[d]), 32'd1);
                tick();
                n++;
            end
            check({tag, "_gap"},     32'(n), 32'(gd(d)));
            check({tag, "_sckidle"}, 32'(sck_v[d]), 32'(pol(d)));
        end else begin
            check({tag, "_cskeep"}, 32'(cs_v[d]), 32'd0);
            tick();
        end
        check({tag, "_ndcnt"}, 32'(nd_cnt[d] - s_nd), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, s_low, s_nd, s_lead, s_rise;
        logic [31:0] r, prior;

        #2 rst = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_cs",   32'(cs_v[d]),   32'd1);
            check("rst_sck",  32'(sck_v[d]),  32'(pol(d)));
            check("rst_mosi", 32'(mosi_v[d]), 32'd0);
            check("rst_dout", dout(d),        32'd0);
            check("rst_busy", 32'(busy_v[d]), 32'd0);
            check("rst_nd",   32'(nd_v[d]),   32'd0);
        end
        rst = 1'b1;
        tick();

        // Loopback frame, then random words on both masters.
        loop0 = 1'b1;
        frame(0, 32'hA5, 1'b0, 32'hA5, "loop_a5");
        loop0 = 1'b0;
        for (int i = 0; i < 3; i++) frame(0, $urandom, 1'b0, $urandom, "rand8");
        frame(1, $urandom, 1'b0, 32'h0012_3456, "tdc24");
        frame(1, $urandom, 1'b0, $urandom, "rand24");

        // Burst of three words: CS must rise exactly once, after the last.
        s_rise = cs_rise[0];
        frame(0, 32'h01, 1'b1, $urandom, "burst1");
        frame(0, 32'h02, 1'b1, $urandom, "burst2");
        frame(0, 32'h03, 1'b0, $urandom, "burst3");
        check("burst_rise", 32'(cs_rise[0] - s_rise), 32'd1);

        // start held high for the whole frame and its gap.
        wait_idle(0, "hold");
        r = $urandom;
        arm_slave(0, r);
        s_low = cs_low[0]; s_lead = lead[0];
        drive(0, 1'b1, 32'h5C, 1'b0, 1'b0);
        n = 0;
        while (!nd_v[0] && n < 1000) begin tick(); n++; end
        check("hold_nd",     32'(nd_v[0]), 32'd1);
        check("hold_pulses", 32'(lead[0] - s_lead), 32'(W0));
        check("hold_cslow",  32'(cs_low[0] - s_low), 32'((2 * W0 + 2) * H0));
        check("hold_dout",   dout(0), r & 32'hFF);
        n = 0;
        while (busy_v[0] && n < 100) begin tick(); n++; end
        check("hold_gap", 32'(n), 32'(G0));
        r = $urandom;
        arm_slave(0, r);
        s_lead = lead[0];
        tick();
        drive(0, 1'b0, 32'h5C, 1'b0, 1'b0);
        check("hold_restart", 32'(busy_v[0]), 32'd1);
        n = 0;
        while (!nd_v[0] && n < 1000) begin tick(); n++; end
        check("hold2_dout",   dout(0), r & 32'hFF);
        check("hold2_mosi",   rx[0] & 32'hFF, 32'h5C);
        check("hold2_pulses", 32'(lead[0] - s_lead), 32'(W0));
        prior = r & 32'hFF;

        // Abort at the fifth SCK edge of an all-ones word.
        wait_idle(0, "abort");
        arm_slave(0, $urandom);
        s_nd = nd_cnt[0];
        drive(0, 1'b1, 32'hFF, 1'b0, 1'b0);
        tick();
        drive(0, 1'b0, 32'hFF, 1'b0, 1'b0);
        n = 0;
        while ((lead[0] + trail[0] - b_lead[0] - b_trail[0]) < 5 && n < 1000) begin tick(); n++; end
        check("abort_edges", 32'(lead[0] + trail[0] - b_lead[0] - b_trail[0]), 32'd5);
        drive(0, 1'b0, 32'hFF, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 32'hFF, 1'b0, 1'b0);
        check("abort_cs",   32'(cs_v[0]),   32'd1);
        check("abort_sck",  32'(sck_v[0]),  32'(POL0));
        check("abort_mosi", 32'(mosi_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd1);
        n = 0;
        while (busy_v[0] && n < 100) begin tick(); n++; end
        check("abort_gap",  32'(n), 32'(G0));
        check("abort_nd",   32'(nd_cnt[0] - s_nd), 32'd0);
        check("abort_dout", dout(0), prior);

        // abort and start together in IDLE: abort wins, no frame.
        s_low = cs_low[0]; s_nd = nd_cnt[0];
        drive(0, 1'b1, $urandom, 1'b0, 1'b1);
        tick();
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("absta_busy", 32'(busy_v[0]), 32'd1);
        check("absta_cs",   32'(cs_v[0]),   32'd1);
        n = 0;
        while (busy_v[0] && n < 100) begin tick(); n++; end
        check("absta_gap",   32'(n), 32'(G0));
        check("absta_cslow", 32'(cs_low[0] - s_low), 32'd0);
        check("absta_nd",    32'(nd_cnt[0] - s_nd), 32'd0);
        check("absta_dout",  dout(0), prior);

        // Asynchronous reset between clock edges in the middle of a frame.
        wait_idle(1, "arst");
        arm_slave(1, $urandom);
        s_nd = nd_cnt[1];
        drive(1, 1'b1, $urandom, 1'b0, 1'b0);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_cs",   32'(cs_v[1]),   32'd1);
        check("arst_sck",  32'(sck_v[1]),  32'(POL1));
        check("arst_busy", 32'(busy_v[1]), 32'd0);
        check("arst_dout", dout(1),        32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("arst_nd", 32'(nd_cnt[1] - s_nd), 32'd0);
        frame(1, $urandom, 1'b0, $urandom, "post_rst24");
        frame(0, $urandom, 1'b0, $urandom, "post_rst8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
